alu_op_sequencer: RTL and testbench

//  Command-queue controller for the 4-bit-operand ALU with 8-bit accumulator on the lab board.

---
 rtl/alu_seq_pkg.sv | 29 ++
 rtl/alu_seq_fifo.sv | 55 +++++
 rtl/alu_op_sequencer.sv | 148 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_seq_pkg;

    localparam int unsigned FUNC_W = 3;
    localparam int unsigned OPND_W = 4;
    localparam int unsigned ACC_W  = 8;
    localparam int unsigned CMD_W  = FUNC_W + OPND_W;

    localparam logic [FUNC_W-1:0] FN_INC   = 3'b111;
    localparam logic [FUNC_W-1:0] FN_ADD5  = 3'b110;
    localparam logic [FUNC_W-1:0] FN_ADD8  = 3'b101;
    localparam logic [FUNC_W-1:0] FN_XOROR = 3'b100;
    localparam logic [FUNC_W-1:0] FN_ROR   = 3'b011;
    localparam logic [FUNC_W-1:0] FN_SHL   = 3'b010;
    localparam logic [FUNC_W-1:0] FN_SHR   = 3'b001;
    localparam logic [FUNC_W-1:0] FN_MUL   = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [FUNC_W-1:0] func;
        logic [OPND_W-1:0] a;
    } cmd_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous command FIFO with occupancy count; head is read combinationally.
module alu_seq_fifo
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
)
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  cmd_t                   din,
    input  logic                   pop,
    output cmd_t                   dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues {func, A} ALU commands and executes them in order against an 8-bit accumulator (B = acc[3:0]).
// Build option: define ALU_SEQ_MULT_SERIAL_EN for a 4-cycle shift-add multiply instead of a combinational one.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
)
(
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [2:0]                  cmd_func,
    input  logic [3:0]                  cmd_a,
    output logic [7:0]                  acc_out,
    output logic                        done,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    state_t            state;
    cmd_t              cmd_in;
    cmd_t              head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [FUNC_W-1:0] op_func;
    logic [OPND_W-1:0] op_a;
    logic [OPND_W-1:0] op_b;
    logic [ACC_W-1:0]  result;
    logic [OPND_W-1:0] shl4;
    logic [OPND_W-1:0] shr4;
    logic [OPND_W:0]   sum5;

`ifdef ALU_SEQ_MULT_SERIAL_EN
    logic [ACC_W-1:0]  prod;
    logic [1:0]        cnt;
    logic [ACC_W-1:0]  mul_term;
`endif

    assign cmd_in    = '{func: cmd_func, a: cmd_a};
    assign push      = cmd_valid & ~full;
    assign pop       = (state == ST_IDLE) & ~empty;
    assign cmd_ready = ~full;
    assign busy      = (state != ST_IDLE) | ~empty;

    alu_seq_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (cmd_in),
        .pop     (pop),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    // ALU result mux; narrow results are zero-extended to the accumulator width.
    always_comb begin
        result = '0;
        sum5   = {1'b0, op_a} + {1'b0, op_b};
        shl4   = op_b << op_a[1:0];
        shr4   = op_b >> op_a[1:0];
        case (op_func)
            FN_INC:          result = {4'd0, op_a} + ACC_W'(1);
            FN_ADD5,
            FN_ADD8:         result = ACC_W'(sum5);
            FN_XOROR:        result = {op_a ^ op_b, op_a | op_b};
            FN_ROR:          result = ACC_W'(|{op_a, op_b});
            FN_SHL:          result = (op_a[3:2] != 2'b00) ? '0 : {4'd0, shl4};
            FN_SHR:          result = (op_a[3:2] != 2'b00) ? '0 : {4'd0, shr4};
`ifdef ALU_SEQ_MULT_SERIAL_EN
            FN_MUL:          result = '0;
`else
            FN_MUL:          result = ACC_W'(op_a) * ACC_W'(op_b);
`endif
            default:         result = '0;
        endcase
    end

`ifdef ALU_SEQ_MULT_SERIAL_EN
    // One partial product per MUL cycle, selected by bit cnt of A.
    always_comb begin
        mul_term = '0;
        if (op_a[cnt]) mul_term = ACC_W'(op_b) << cnt;
    end
`endif

    // Issue/execute FSM; done is a one-cycle pulse after each accumulator write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            acc_out <= '0;
            done    <= 1'b0;
            op_func <= '0;
            op_a    <= '0;
            op_b    <= '0;
`ifdef ALU_SEQ_MULT_SERIAL_EN
            prod    <= '0;
            cnt     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        op_func <= head.func;
                        op_a    <= head.a;
                        op_b    <= acc_out[3:0];
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
`ifdef ALU_SEQ_MULT_SERIAL_EN
                    if (op_func == FN_MUL) begin
                        prod  <= '0;
                        cnt   <= '0;
                        state <= ST_MUL;
                    end else
`endif
                    begin
                        acc_out <= result;
                        done    <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
`ifdef ALU_SEQ_MULT_SERIAL_EN
                ST_MUL: begin
                    if (cnt == 2'd3) begin
                        acc_out <= prod + mul_term;
                        done    <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        prod <= prod + mul_term;
                        cnt  <= cnt + 2'd1;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: directed cases, back-pressure, mid-run reset, random traffic.
module tb_alu_op_sequencer;

    localparam int DEPTH = 4;
`ifdef ALU_SEQ_MULT_SERIAL_EN
    localparam int MUL_LAT = 6;
`else
    localparam int MUL_LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_func = 3'd0;
    logic [3:0] cmd_a = 4'd0;
    logic [7:0] acc_out;
    logic       done;
    logic       busy;
    logic [2:0] fifo_count;

    int total = 0;
    int bad = 0;
    int exp_q[$];
    int model_acc = 0;
    int max_count = 0;
    bit saw_not_ready = 1'b0;
    bit prev_done = 1'b0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_func   (cmd_func),
        .cmd_a      (cmd_a),
        .acc_out    (acc_out),
        .done       (done),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    // Reference ALU from the function table, using plain integer arithmetic.
    function automatic int ref_alu(int f, int a, int b);
        case (f)
            7:       return a + 1;
            6, 5:    return a + b;
            4:       return (a ^ b) * 16 + (a | b);
            3:       return (a != 0 || b != 0) ? 1 : 0;
            2:       return (a >= 4) ? 0 : (b * (1 << a)) % 16;
            1:       return b / (1 << a);
            default: return a * b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name, input int act, input int exp);
        total++;
        bad++;
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Holds cmd_valid until accepted; on acceptance the model result is queued.
    task automatic push_cmd(input logic [2:0] f, input logic [3:0] a);
        bit r;
        bit ok = 1'b0;
        cmd_func  = f;
        cmd_a     = a;
        cmd_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            r = cmd_ready;
            @(posedge clk);
            if (r) begin
                ok = 1'b1;
                model_acc = ref_alu(int'(f), int'(a), model_acc % 16);
                exp_q.push_back(model_acc);
                break;
            end
        end
        #1;
        cmd_valid = 1'b0;
        if (!ok) note_fail("push_timeout", 0, 1);
    endtask

    // Single command into an idle block: checks write latency, value and pulse width.
    task automatic run_one(input logic [2:0] f, input logic [3:0] a, input int exp, input int lat);
        int seen = -1;
        push_cmd(f, a);
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = k;
                break;
            end
            check("busy_before_done", 32'(busy), 32'd1);
        end
        check("latency", 32'(seen), 32'(lat));
        check("acc_value", 32'(acc_out), 32'(exp));
        @(posedge clk);
        #1;
        check("done_width", 32'(done), 32'd0);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) note_fail("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected results on done and checks outstanding-work invariants.
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                check("done_spacing", 32'(prev_done), 32'd0);
                if (exp_q.size() == 0) note_fail("unexpected_done", 1, 0);
                else check("scoreboard_acc", 32'(acc_out), 32'(exp_q.pop_front()));
            end
            prev_done = (done === 1'b1);
            check("busy_vs_model", 32'(busy), 32'(exp_q.size() != 0));
            total++;
            if (int'(fifo_count) > exp_q.size() || int'(fifo_count) + 1 < exp_q.size()) begin
                bad++;
                $display("FAIL fifo_count: got %0d expected %0d or %0d at %0t",
                         fifo_count, exp_q.size(), exp_q.size() - 1, $time);
            end
            if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
            if (cmd_ready === 1'b0) saw_not_ready = 1'b1;
        end
    end

    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        exp_q.delete();
        model_acc = 0;
        #1;
        reset_n = 1'b1;
        check("rst_acc", 32'(acc_out), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);

        run_one(3'b111, 4'd5, 8'h06, 2);
        run_one(3'b110, 4'd9, 8'h0F, 2);
        run_one(3'b100, 4'd3, 8'hCF, 2);
        run_one(3'b110, 4'd0, 8'h0F, 2);
        run_one(3'b000, 4'hF, 8'hE1, MUL_LAT);
        run_one(3'b111, 4'd2, 8'h03, 2);
        run_one(3'b010, 4'd2, 8'h0C, 2);
        run_one(3'b001, 4'd5, 8'h00, 2);
        run_one(3'b111, 4'd2, 8'h03, 2);
        run_one(3'b011, 4'd0, 8'h01, 2);
        run_one(3'b101, 4'd7, 8'h08, 2);
        run_one(3'b010, 4'd4, 8'h00, 2);

        // Back-pressure: a multiply followed by a burst fills the FIFO.
        max_count = 0;
        saw_not_ready = 1'b0;
        push_cmd(3'b000, 4'd7);
        for (int i = 0; i < 8; i++)
            push_cmd(3'($urandom_range(1, 7)), 4'($urandom_range(0, 15)));
        wait_idle();
        check("peak_count", 32'(max_count), 32'd4);
        check("saw_not_ready", 32'(saw_not_ready), 32'd1);

        // Random traffic with random gaps.
        for (int i = 0; i < 60; i++) begin
            push_cmd(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_idle();

        // One-cycle reset while a multiply is in flight and two commands are queued.
        push_cmd(3'b000, 4'($urandom_range(1, 15)));
        push_cmd(3'b111, 4'd1);
        push_cmd(3'b110, 4'd2);
        reset_n = 1'b0;
        @(posedge clk);
        exp_q.delete();
        model_acc = 0;
        #1;
        reset_n = 1'b1;
        check("midrst_acc", 32'(acc_out), 32'd0);
        check("midrst_count", 32'(fifo_count), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("postrst_acc", 32'(acc_out), 32'd0);
        check("postrst_busy", 32'(busy), 32'd0);

        run_one(3'b111, 4'd9, 8'h0A, 2);
        wait_idle();
        check("leftover_expected", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
